lcv_mul_acc_arb: RTL

LCV_MUL_ACC_ARB -- requirements
Module: lcv_mul_acc_arb

---
 rtl/lcv_mul_acc_arb_pkg.sv | 15 +
 rtl/lcv_mul_acc_arb_if.sv | 31 +++
 rtl/lcv_mul_acc_arb_mac_stage.sv | 32 +++
 rtl/lcv_mul_acc_arb.sv | 111 +++++++++++
 4 files changed

// File: rtl/lcv_mul_acc_arb_pkg.sv
// Shared widths and the result record for the round-robin multiply-accumulate arbiter.
package lcv_mul_acc_pkg;

  localparam int LCV_MAC_OPND_W   = 16;
  localparam int LCV_MAC_ACC_W    = 33;
  localparam int LCV_MAC_PROD_W   = 36;
  // Widest requester ID needed for the largest legal NUM_REQ (8).
  localparam int LCV_MAC_ID_MAX_W = 3;

  typedef struct packed {
    logic [LCV_MAC_ACC_W-1:0]    data;
    logic [LCV_MAC_ID_MAX_W-1:0] id;
  } lcv_mac_res_t;

endpackage

// File: rtl/lcv_mul_acc_arb_if.sv
// Requester and result bus between the requesters/consumer (master) and the arbiter (slave).
interface lcv_mul_acc_if
  import lcv_mul_acc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*LCV_MAC_OPND_W-1:0] req_a;
  logic [NUM_REQ*LCV_MAC_OPND_W-1:0] req_b;
  logic [NUM_REQ*LCV_MAC_ACC_W-1:0]  req_c;
  logic [NUM_REQ*LCV_MAC_ACC_W-1:0]  req_d;
  logic [NUM_REQ*LCV_MAC_ACC_W-1:0]  req_e;
  logic                              res_valid;
  logic                              res_ready;
  logic [LCV_MAC_ACC_W-1:0]          res_data;
  logic [ID_W-1:0]                   res_id;

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, req_e, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, req_e, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/lcv_mul_acc_arb_mac_stage.sv
// Registered a*b+c+d+e with clock enable; the sum is formed at 36 bits and wrapped to 33.
(* use_dsp = "yes" *)
module lcv_mac_stage
  import lcv_mul_acc_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic signed [LCV_MAC_OPND_W-1:0] a,
  input  logic signed [LCV_MAC_OPND_W-1:0] b,
  input  logic signed [LCV_MAC_ACC_W-1:0]  c,
  input  logic signed [LCV_MAC_ACC_W-1:0]  d,
  input  logic signed [LCV_MAC_ACC_W-1:0]  e,
  output logic signed [LCV_MAC_ACC_W-1:0]  q
);

  logic signed [LCV_MAC_PROD_W-1:0] sum;

  always_comb begin
    sum = LCV_MAC_PROD_W'(a) * LCV_MAC_PROD_W'(b)
        + LCV_MAC_PROD_W'(c) + LCV_MAC_PROD_W'(d) + LCV_MAC_PROD_W'(e);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= sum[LCV_MAC_ACC_W-1:0];
    end
  end

endmodule

// File: rtl/lcv_mul_acc_arb.sv
// Round-robin arbiter sharing one registered multiply-accumulate stage among NUM_REQ requesters.
module lcv_mul_acc_arb
  import lcv_mul_acc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic           clk,
  input logic           rst,
  lcv_mul_acc_if.slave  bus
);

  logic [ID_W-1:0]                  ptr;
  logic [ID_W-1:0]                  ptr_next;
  logic [ID_W-1:0]                  grant_idx;
  logic [ID_W-1:0]                  res_id_q;
  logic [ID_W:0]                    cand_w;
  logic [ID_W:0]                    inc_w;
  logic                             grant_any;
  logic                             grant;
  logic                             res_valid_q;
  logic signed [LCV_MAC_OPND_W-1:0] sel_a;
  logic signed [LCV_MAC_OPND_W-1:0] sel_b;
  logic signed [LCV_MAC_ACC_W-1:0]  sel_c;
  logic signed [LCV_MAC_ACC_W-1:0]  sel_d;
  logic signed [LCV_MAC_ACC_W-1:0]  sel_e;
  logic signed [LCV_MAC_ACC_W-1:0]  mac_q;
  lcv_mac_res_t                     res_out;

  // Search starts at ptr and wraps; the first valid requester found wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_w    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand_w >= (ID_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && bus.req_valid[cand_w[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand_w[ID_W-1:0];
      end
    end
  end

  always_comb begin
    inc_w = {1'b0, grant_idx} + (ID_W+1)'(1);
    if (inc_w >= (ID_W+1)'(NUM_REQ)) begin
      inc_w = '0;
    end
    ptr_next = inc_w[ID_W-1:0];
  end

  // A grant needs the output register to be empty or draining this cycle.
  assign grant         = rst && grant_any && (!res_valid_q || bus.res_ready);
  assign bus.req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_a = bus.req_a[LCV_MAC_OPND_W-1:0];
    sel_b = bus.req_b[LCV_MAC_OPND_W-1:0];
    sel_c = bus.req_c[LCV_MAC_ACC_W-1:0];
    sel_d = bus.req_d[LCV_MAC_ACC_W-1:0];
    sel_e = bus.req_e[LCV_MAC_ACC_W-1:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = bus.req_a[i*LCV_MAC_OPND_W +: LCV_MAC_OPND_W];
        sel_b = bus.req_b[i*LCV_MAC_OPND_W +: LCV_MAC_OPND_W];
        sel_c = bus.req_c[i*LCV_MAC_ACC_W +: LCV_MAC_ACC_W];
        sel_d = bus.req_d[i*LCV_MAC_ACC_W +: LCV_MAC_ACC_W];
        sel_e = bus.req_e[i*LCV_MAC_ACC_W +: LCV_MAC_ACC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr         <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
    end else if (grant) begin
      ptr         <= ptr_next;
      res_valid_q <= 1'b1;
      res_id_q    <= grant_idx;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  lcv_mac_stage u_mac (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .a   (sel_a),
    .b   (sel_b),
    .c   (sel_c),
    .d   (sel_d),
    .e   (sel_e),
    .q   (mac_q)
  );

  always_comb begin
    res_out.data = mac_q;
    res_out.id   = LCV_MAC_ID_MAX_W'(res_id_q);
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_out.data;
  assign bus.res_id    = res_out.id[ID_W-1:0];

endmodule
